logic_sweep_unit: RTL and testbench
===================================

LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

Interface
REQ-001 Parameter WIDTH, default 4, is the operand width in bits; legal range 1..8.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 Port func  input  4  truth table of a 2-input function; result bit = func[{a,b}]. Implication ~a|b = 4'b1011; a|~b = 4'b1101.
REQ-006 Port ready  input  1  downstream accepts the current result.
REQ-007 Port x  output  WIDTH  current first operand.
REQ-008 Port y  output  WIDTH  current second operand.
REQ-009 Port s  output  WIDTH  bitwise result, s[i] = func[{x[i],y[i]}].
REQ-010 Port valid  output  1  x, y and s form a valid result.
REQ-011 Port busy  output  1  high in RUN and DONE.
REQ-012 Port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-013 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch func into an internal register, load x=0 and y=0, and enter RUN on the next edge.
REQ-015 In RUN, valid SHALL be 1, and s SHALL be a registered output derived from the latched func.
REQ-016 A handshake SHALL occur on any edge where valid=1 and ready=1; no other event advances the sweep.
REQ-017 On a handshake, the 2*WIDTH-bit value {x,y} SHALL increment by 1, with y as the low half, so that y wraps into x.
REQ-018 The handshake at {x,y} all-ones SHALL NOT wrap; the block SHALL instead enter DONE, and valid SHALL fall.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
REQ-020 While valid=1 and ready=0, x, y and s SHALL hold unchanged.
REQ-021 A sweep SHALL produce exactly 2^(2*WIDTH) handshakes.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 Changes on func during RUN SHALL NOT affect s.
REQ-024 start=1 in the IDLE cycle that directly follows DONE SHALL begin a new sweep.
REQ-025 In IDLE, x, y and s SHALL retain their last values, and valid SHALL be 0.

Reset
REQ-026 When rst_n=0 at a rising edge, the state SHALL become IDLE, and x, y, s, valid, busy and done SHALL all become 0.
REQ-027 A reset during RUN or DONE SHALL abort the sweep without asserting done.
REQ-028 After a reset, the block SHALL be ready for a new start on the next cycle.

Configuration
REQ-029 When macro LSU_ONES_EN is defined, the block SHALL add output ones of width 2*WIDTH+4.
REQ-030 With LSU_ONES_EN defined, ones SHALL clear on sweep start and on reset.
REQ-031 With LSU_ONES_EN defined, each handshake SHALL add the popcount of s to ones.
REQ-032 With LSU_ONES_EN defined, ones SHALL hold its final value from the DONE cycle until the next start or reset.
REQ-033 Without LSU_ONES_EN, the ones port and its adder SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=1, func=4'b1011, ready=1, pulse start -> (x,y,s) = (0,0,1), (0,1,1), (1,0,0), (1,1,1) on 4 consecutive cycles; done one cycle after the 4th handshake.
REQ-035 WIDTH=1, func=4'b1101 -> s sequence 1,0,1,1; changing func to 4'b0000 mid-sweep leaves the sequence unchanged.
REQ-036 WIDTH=2, ready toggled 1/0 each cycle -> 16 handshakes with {x,y} = 0..15 in order; x, y and s stable while ready=0; done once.
REQ-037 rst_n=0 after the 5th handshake of a WIDTH=2 sweep -> next cycle state IDLE and all outputs 0; no done pulse; a following start begins again at {x,y}=0.
REQ-038 start held high throughout a WIDTH=1 sweep -> exactly 4 handshakes before done, then a second sweep begins in the IDLE cycle after DONE.
REQ-039 LSU_ONES_EN defined, WIDTH=2, func=4'b1011 -> ones = 24 at DONE; func=4'b1111 -> ones = 32; func=4'b0000 -> ones = 0.

Source files
------------

// File: rtl/logic_sweep_unit.sv
// Sweeps every {x,y} operand pair through a latched 2-input truth table, one result per handshake.
// Define LSU_ONES_EN to add the "ones" output, a running popcount of all accepted results.
module logic_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic             ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             valid,
    output logic             busy,
    output logic             done
`ifdef LSU_ONES_EN
    ,
    output logic [2*WIDTH+3:0] ones
`endif
);

    localparam int CW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      func_q, func_d;
    logic [CW-1:0]   xy_q, xy_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic            load;
    logic            handshake;
    logic            last;

    function automatic logic [WIDTH-1:0] applyFunc(input logic [3:0]       tt,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = tt[{a[i], b[i]}];
        end
        return r;
    endfunction

    assign load      = (state_q == IDLE) && start;
    assign handshake = (state_q == RUN) && ready;
    assign last      = &xy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (handshake && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // s is precomputed for the operands about to be shown, so it is valid in the same cycle as x/y.
    always_comb begin
        func_d = func_q;
        xy_d   = xy_q;
        s_d    = s_q;
        if (load) begin
            func_d = func;
            xy_d   = '0;
            s_d    = applyFunc(func, '0, '0);
        end else if (handshake && !last) begin
            xy_d = xy_q + CW'(1);
            s_d  = applyFunc(func_q, xy_d[CW-1:WIDTH], xy_d[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            func_q <= '0;
            xy_q   <= '0;
            s_q    <= '0;
        end else begin
            func_q <= func_d;
            xy_q   <= xy_d;
            s_q    <= s_d;
        end
    end

    assign x = xy_q[CW-1:WIDTH];
    assign y = xy_q[WIDTH-1:0];
    assign s = s_q;

`ifdef LSU_ONES_EN
    logic [CW+3:0] ones_q, ones_d;

    function automatic logic [CW+3:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW+3:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (CW+4)'(v[i]);
        end
        return c;
    endfunction

    // Counts the result being accepted, i.e. the s visible before the handshake edge.
    always_comb begin
        ones_d = ones_q;
        if (load) begin
            ones_d = '0;
        end else if (handshake) begin
            ones_d = ones_q + popcount(s_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones = ones_q;
`endif

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Bench for logic_sweep_unit: a WIDTH=1 and a WIDTH=2 instance checked every cycle against an index-based model.
// Literal sequences pin the model; LSU_ONES_EN also enables the ones checks.
module tb_logic_sweep_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rstN;
    logic [1:0]      startV;
    logic [1:0]      readyV;
    logic [1:0][3:0] funcV;
    logic [0:0]      x0, y0, s0;
    logic [1:0]      x1, y1, s1;
    logic [1:0]      validV, busyV, doneV;
`ifdef LSU_ONES_EN
    logic [5:0]      ones0;
    logic [7:0]      ones1;
`endif

    logic_sweep_unit #(.WIDTH(1)) dut0 (
        .clk(clk), .rst_n(rstN[0]), .start(startV[0]), .func(funcV[0]), .ready(readyV[0]),
        .x(x0), .y(y0), .s(s0), .valid(validV[0]), .busy(busyV[0]), .done(doneV[0])
`ifdef LSU_ONES_EN
        , .ones(ones0)
`endif
    );

    logic_sweep_unit #(.WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rstN[1]), .start(startV[1]), .func(funcV[1]), .ready(readyV[1]),
        .x(x1), .y(y1), .s(s1), .valid(validV[1]), .busy(busyV[1]), .done(doneV[1])
`ifdef LSU_ONES_EN
        , .ones(ones1)
`endif
    );

    int checks = 0;
    int fails  = 0;
    bit live   = 1'b0;

    int         mPhase[2];
    int         mIdx[2];
    int         mX[2], mY[2], mS[2], mOnes[2];
    logic [3:0] mFunc[2];
    int         hsCount[2] = '{0, 0};
    int         doneCount[2] = '{0, 0};

    function automatic int sOf(input logic [3:0] f, input int xv, input int yv, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (f[((xv >> i) & 1) * 2 + ((yv >> i) & 1)]) r |= (1 << i);
        end
        return r;
    endfunction

    function automatic int popcnt(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int dutX(input int k);
        return (k == 0) ? int'(x0) : int'(x1);
    endfunction
    function automatic int dutY(input int k);
        return (k == 0) ? int'(y0) : int'(y1);
    endfunction
    function automatic int dutS(input int k);
        return (k == 0) ? int'(s0) : int'(s1);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input bit r, input bit st, input logic [3:0] f, input bit rd);
        rstN[k]   = r;
        startV[k] = st;
        funcV[k]  = f;
        readyV[k] = rd;
    endtask

    task automatic waitDone(input int k, input int limit, input string tag);
        int c = 0;
        while (!doneV[k] && c < limit) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, "_doneSeen"}, int'(doneV[k]), 1);
    endtask

    // Model: a sweep is just an index 0..2^(2w)-1; x/y are its halves, s is looked up from the latched table.
    always @(posedge clk) begin
        int w;
        int lastIdx;
        for (int k = 0; k < 2; k++) begin
            w = k + 1;
            lastIdx = (1 << (2 * w)) - 1;
            if (validV[k] && readyV[k]) hsCount[k]++;
            if (!rstN[k]) begin
                mPhase[k] = 0;
                mIdx[k]   = 0;
                mX[k]     = 0;
                mY[k]     = 0;
                mS[k]     = 0;
                mOnes[k]  = 0;
            end else begin
                case (mPhase[k])
                    0: if (startV[k]) begin
                        mFunc[k]  = funcV[k];
                        mIdx[k]   = 0;
                        mOnes[k]  = 0;
                        mPhase[k] = 1;
                    end
                    1: if (readyV[k]) begin
                        mOnes[k] += popcnt(mS[k]);
                        if (mIdx[k] == lastIdx) mPhase[k] = 2;
                        else mIdx[k]++;
                    end
                    default: mPhase[k] = 0;
                endcase
                if (mPhase[k] == 1) begin
                    mX[k] = mIdx[k] >> w;
                    mY[k] = mIdx[k] & ((1 << w) - 1);
                    mS[k] = sOf(mFunc[k], mX[k], mY[k], w);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("x%0d", k), dutX(k), mX[k]);
                checkOutput($sformatf("y%0d", k), dutY(k), mY[k]);
                checkOutput($sformatf("s%0d", k), dutS(k), mS[k]);
                checkOutput($sformatf("valid%0d", k), int'(validV[k]), int'(mPhase[k] == 1));
                checkOutput($sformatf("busy%0d", k), int'(busyV[k]), int'(mPhase[k] != 0));
                checkOutput($sformatf("done%0d", k), int'(doneV[k]), int'(mPhase[k] == 2));
`ifdef LSU_ONES_EN
                checkOutput($sformatf("ones%0d", k), (k == 0) ? int'(ones0) : int'(ones1), mOnes[k]);
`endif
                if (doneV[k]) doneCount[k]++;
            end
        end
    end

    int litA[4] = '{1, 3, 4, 7};
    int litB[4] = '{1, 0, 1, 1};
`ifdef LSU_ONES_EN
    logic [3:0] onesFunc[3] = '{4'b1011, 4'b1111, 4'b0000};
    int         onesExp[3]  = '{24, 32, 0};
`endif

    initial begin
        int d0;
        int h0;
        rstN   = 2'b00;
        startV = 2'b00;
        readyV = 2'b00;
        funcV  = '0;
        repeat (2) @(negedge clk);
        live = 1'b1;
        checkOutput("rst_x1", int'(x1), 0);
        checkOutput("rst_valid0", int'(validV[0]), 0);
        checkOutput("rst_busy1", int'(busyV[1]), 0);
        rstN = 2'b11;
        @(negedge clk);

        // Implication table on WIDTH=1, ready always high.
        applyStimulus(0, 1, 1, 4'b1011, 1);
        @(negedge clk);
        startV[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("A_xys%0d", i), int'({x0, y0, s0}), litA[i]);
            @(negedge clk);
        end
        checkOutput("A_done", int'(doneV[0]), 1);
        @(negedge clk);
        checkOutput("A_doneOnce", int'(doneV[0]), 0);

        // Reverse implication; table changed mid-sweep must not matter.
        applyStimulus(0, 1, 1, 4'b1101, 1);
        @(negedge clk);
        startV[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("B_s%0d", i), int'(s0), litB[i]);
            if (i == 1) funcV[0] = 4'b0000;
            @(negedge clk);
        end
        checkOutput("B_done", int'(doneV[0]), 1);
        @(negedge clk);

        // WIDTH=2 with ready toggling every cycle.
        d0 = doneCount[1];
        h0 = hsCount[1];
        applyStimulus(1, 1, 1, 4'($urandom), 1);
        @(negedge clk);
        startV[1] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (doneV[1]) break;
            readyV[1] = ~readyV[1];
            @(negedge clk);
        end
        checkOutput("C_doneSeen", int'(doneV[1]), 1);
        @(negedge clk);
        checkOutput("C_handshakes", hsCount[1] - h0, 16);
        checkOutput("C_doneCount", doneCount[1] - d0, 1);

        // Reset after the fifth handshake aborts the sweep silently.
        h0 = hsCount[1];
        applyStimulus(1, 1, 1, 4'b1011, 1);
        @(negedge clk);
        startV[1] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("D_hsBeforeReset", hsCount[1] - h0, 5);
        d0 = doneCount[1];
        rstN[1] = 1'b0;
        @(negedge clk);
        checkOutput("D_x", int'(x1), 0);
        checkOutput("D_y", int'(y1), 0);
        checkOutput("D_s", int'(s1), 0);
        checkOutput("D_validBusyDone", int'({validV[1], busyV[1], doneV[1]}), 0);
        applyStimulus(1, 1, 1, 4'b1011, 1);
        @(negedge clk);
        startV[1] = 1'b0;
        checkOutput("D_noDone", doneCount[1] - d0, 0);
        checkOutput("D_restartXY", int'({x1, y1}), 0);
        checkOutput("D_restartValid", int'(validV[1]), 1);
        waitDone(1, 40, "D");
        @(negedge clk);

        // start held high: DONE ignores it, the following IDLE cycle restarts.
        h0 = hsCount[0];
        applyStimulus(0, 1, 1, 4'($urandom), 1);
        waitDone(0, 20, "E");
        checkOutput("E_handshakes", hsCount[0] - h0, 4);
        @(negedge clk);
        checkOutput("E_idleGap", int'({validV[0], busyV[0]}), 0);
        @(negedge clk);
        checkOutput("E_restartValid", int'(validV[0]), 1);
        checkOutput("E_restartXY", int'({x0, y0}), 0);
        startV[0] = 1'b0;
        waitDone(0, 20, "E2");
        @(negedge clk);

`ifdef LSU_ONES_EN
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1, 1, 1, onesFunc[t], 1);
            @(negedge clk);
            startV[1] = 1'b0;
            waitDone(1, 40, "F");
            checkOutput($sformatf("F_ones%0d", t), int'(ones1), onesExp[t]);
            @(negedge clk);
            checkOutput($sformatf("F_onesHold%0d", t), int'(ones1), onesExp[t]);
        end
`endif

        // Randomized traffic on both instances, including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                applyStimulus(k, $urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0,
                              4'($urandom), $urandom_range(0, 2) != 0);
            end
            @(negedge clk);
        end
        rstN   = 2'b11;
        startV = 2'b00;
        readyV = 2'b11;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
